// File: rtl/det3_pkg.sv
// Shared types and constants for the sequential 3x3 determinant engine.
// Contents: FSM state enum, element indices A..I, step/element counts,
//   and the six-entry cofactor term table (x, y, z element index + sign).
package det3_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DONE} state_t;

  // Row-major element indices: [[a,b,c],[d,e,f],[g,h,i]]
  localparam logic [3:0] A = 4'd0;
  localparam logic [3:0] B = 4'd1;
  localparam logic [3:0] C = 4'd2;
  localparam logic [3:0] D = 4'd3;
  localparam logic [3:0] E = 4'd4;
  localparam logic [3:0] F = 4'd5;
  localparam logic [3:0] G = 4'd6;
  localparam logic [3:0] H = 4'd7;
  localparam logic [3:0] I = 4'd8;

  localparam int N_STEPS = 12;
  localparam int N_ELEM  = 9;

  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
    logic [3:0] z;
    logic       neg;
  } term_t;

  // Term k of det = +aei +bfg +cdh -ceg -bdi -afh
  function automatic term_t term_lookup(input logic [2:0] k);
    term_t t;
    case (k)
      3'd0:    t = '{x: A, y: E, z: I, neg: 1'b0};
      3'd1:    t = '{x: B, y: F, z: G, neg: 1'b0};
      3'd2:    t = '{x: C, y: D, z: H, neg: 1'b0};
      3'd3:    t = '{x: C, y: E, z: G, neg: 1'b1};
      3'd4:    t = '{x: B, y: D, z: I, neg: 1'b1};
      3'd5:    t = '{x: A, y: F, z: H, neg: 1'b1};
      default: t = '{x: A, y: E, z: I, neg: 1'b0};
    endcase
    return t;
  endfunction

endpackage

// File: rtl/det3_mac.sv
// Shared multiply-accumulate: registered EW x EW product, then acc +/- (p * z).
// Latency: product registered one cycle after mul_en; acc updated on acc_en edge.
// Backpressure: none; sequenced entirely by the engine FSM.
// Ports: clk, rst_n, acc_clr (sync zero), mul_en, acc_en, x/y/z elements,
//   sub (subtract term), sum (combinational acc +/- p*z, i.e. next acc value).
module det3_mac #(
  parameter int EW = 4,
  parameter int OW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          acc_clr,
  input  logic          mul_en,
  input  logic          acc_en,
  input  logic [EW-1:0] x,
  input  logic [EW-1:0] y,
  input  logic [EW-1:0] z,
  input  logic          sub,
  output logic [OW-1:0] sum
);

  logic [2*EW-1:0] p_q;
  logic [2*EW-1:0] xe;
  logic [2*EW-1:0] ye;
  logic [3*EW-1:0] pe;
  logic [3*EW-1:0] ze;
  logic [3*EW-1:0] pz;
  logic [OW-1:0]   pz_ext;
  logic [OW-1:0]   acc_q;

  assign xe = {{EW{1'b0}}, x};
  assign ye = {{EW{1'b0}}, y};
  assign pe = {{EW{1'b0}}, p_q};
  assign ze = {{(2*EW){1'b0}}, z};
  assign pz = pe * ze;

  // Triple product is always non-negative, so zero-extension is the sign extension.
  assign pz_ext = {{(OW-3*EW){1'b0}}, pz};
  assign sum    = sub ? (acc_q - pz_ext) : (acc_q + pz_ext);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q   <= '0;
      acc_q <= '0;
    end else begin
      if (mul_en) p_q <= xe * ye;
      if (acc_clr)     acc_q <= '0;
      else if (acc_en) acc_q <= sum;
    end
  end

endmodule

// File: rtl/det3_seq_engine.sv
// Sequential 3x3 determinant: loads 9 unsigned elements, runs 6 triple-product MACs.
// Latency: out_valid rises 12 cycles after the edge accepting the 9th element.
// Backpressure: in_ready low outside IDLE/LOAD or under clear; result held until out_ready.
// Ports: clk, rst_n, clear (sync abort), in_valid/in_ready/in_data (element stream),
//   out_valid/out_ready/det_out (signed result stream), busy (LOAD/COMPUTE/DONE).
module det3_seq_engine
  import det3_pkg::*;
#(
  parameter int EW = 4,
  parameter int OW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [EW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [OW-1:0] det_out,
  output logic          busy
);

  state_t        state_q, state_d;
  logic [3:0]    count_q;
  logic [3:0]    step_q;
  logic [EW-1:0] elem [N_ELEM];
  logic          in_fire;
  logic          last_elem;
  logic          last_step;
  logic          in_compute;
  term_t         term;
  logic [OW-1:0] mac_sum;

  assign in_compute = (state_q == COMPUTE);
  assign last_elem  = (count_q == 4'(N_ELEM - 1));
  assign last_step  = (step_q == 4'(N_STEPS - 1));
  assign in_fire    = in_valid & in_ready;

  // Both phases of a term share the same table entry: k = step / 2.
  assign term = term_lookup(step_q[3:1]);

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      IDLE: begin
        busy     = 1'b0;
        in_ready = ~clear;
        if (in_valid & ~clear) state_d = LOAD;
      end
      LOAD: begin
        in_ready = ~clear;
        if (in_valid & ~clear & last_elem) state_d = COMPUTE;
      end
      COMPUTE: begin
        if (last_step) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (clear) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      step_q  <= '0;
      det_out <= '0;
    end else begin
      state_q <= state_d;

      if (clear)                      count_q <= '0;
      else if (in_fire && last_elem)  count_q <= '0;
      else if (in_fire)               count_q <= count_q + 4'd1;

      if (clear || !in_compute) step_q <= '0;
      else                      step_q <= step_q + 4'd1;

      // The final accumulate lands on the same edge as DONE entry, so take the
      // MAC's next value rather than its register.
      if (in_compute && last_step && !clear) det_out <= mac_sum;
    end
  end

  // Element file carries no reset: every entry is rewritten before it is read.
  always_ff @(posedge clk) begin
    if (in_fire) elem[count_q] <= in_data;
  end

  det3_mac #(.EW(EW), .OW(OW)) u_mac (
    .clk     (clk),
    .rst_n   (rst_n),
    .acc_clr (clear | (in_fire & last_elem)),
    .mul_en  (in_compute & ~step_q[0]),
    .acc_en  (in_compute & step_q[0] & ~clear),
    .x       (elem[term.x]),
    .y       (elem[term.y]),
    .z       (elem[term.z]),
    .sub     (term.neg),
    .sum     (mac_sum)
  );

endmodule

// File: tb/tb_det3_seq_engine.sv
module tb_det3_seq_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] det_out;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int cur[9];

  det3_seq_engine #(.EW(4), .OW(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .det_out   (det_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Cofactor expansion along the first row.
  function automatic logic [15:0] ref_det();
    int d;
    d = cur[0] * (cur[4] * cur[8] - cur[5] * cur[7])
      - cur[1] * (cur[3] * cur[8] - cur[5] * cur[6])
      + cur[2] * (cur[3] * cur[7] - cur[4] * cur[6]);
    return 16'(d);
  endfunction

  task automatic set_cur(input int a, b, c, d, e, f, g, h, i);
    cur = '{a, b, c, d, e, f, g, h, i};
  endtask

  // Streams the first n elements of cur; returns just after the accepting edge.
  task automatic send_cur(input int n, input int gap_pct);
    int idx = 0;
    int guard = 0;
    logic fire;
    while (idx < n && guard < 1000) begin
      @(negedge clk);
      guard++;
      in_valid = ($urandom_range(0, 99) >= gap_pct);
      in_data  = in_valid ? 4'(cur[idx]) : 4'($urandom_range(0, 15));
      #1;
      fire = in_valid & in_ready;
      @(posedge clk);
      if (fire) idx++;
    end
    #1;
    in_valid = 1'b0;
    if (idx < n) check("send_timeout", 32'(idx), 32'(n));
  endtask

  // Waits for out_valid; cycles counted from the accepting edge.
  task automatic wait_result(output int cycles);
    cycles = 0;
    while (out_valid !== 1'b1 && cycles < 200) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    if (out_valid !== 1'b1) check("result_timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic take_result(input string tag, input int hold);
    logic [15:0] exp;
    exp = ref_det();
    check(tag, 32'(det_out), 32'(exp));
    repeat (hold) begin
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_drained"}, 32'({out_valid, busy}), 32'd0);
  endtask

  initial begin
    int cyc;
    logic ok_v, ok_d, ok_r;
    logic [15:0] held;

    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_det_out", 32'(det_out), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed matrix, no gaps, exact latency
    set_cur(2, 3, 1, 4, 1, 5, 6, 2, 3);
    send_cur(9, 0);
    check("busy_after_load", 32'(busy), 32'd1);
    check("in_ready_compute", 32'(in_ready), 32'd0);
    wait_result(cyc);
    check("latency", 32'(cyc), 32'd12);
    check("det_2a_const", 32'(det_out), 32'h002A);
    take_result("det_2a", 0);

    // Identity then swap permutation, back to back
    set_cur(1, 0, 0, 0, 1, 0, 0, 0, 1);
    send_cur(9, 0);
    wait_result(cyc);
    check("ident_const", 32'(det_out), 32'h0001);
    take_result("ident", 0);
    set_cur(0, 1, 0, 1, 0, 0, 0, 0, 1);
    send_cur(9, 0);
    wait_result(cyc);
    check("swap_const", 32'(det_out), 32'hFFFF);
    take_result("swap", 0);

    // diag(15) with gaps
    set_cur(15, 0, 0, 0, 15, 0, 0, 0, 15);
    send_cur(9, 50);
    wait_result(cyc);
    check("diag15_const", 32'(det_out), 32'h0D2F);
    take_result("diag15", 0);

    // Held result under backpressure
    set_cur(3, 7, 2, 9, 1, 4, 6, 8, 5);
    send_cur(9, 20);
    wait_result(cyc);
    held = det_out;
    ok_v = 1'b1; ok_d = 1'b1; ok_r = 1'b1;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b1) ok_v = 1'b0;
      if (det_out !== held) ok_d = 1'b0;
      if (in_ready !== 1'b0) ok_r = 1'b0;
    end
    check("hold_out_valid", 32'(ok_v), 32'd1);
    check("hold_det_out", 32'(ok_d), 32'd1);
    check("hold_in_ready", 32'(ok_r), 32'd0 + 32'd1);
    take_result("hold", 0);
    check("det_holds_in_idle", 32'(det_out), 32'(ref_det()));

    // Abort after 5 elements; clear must block the offered element
    set_cur(9, 9, 9, 9, 9, 9, 9, 9, 9);
    send_cur(5, 0);
    @(negedge clk);
    clear = 1'b1;
    in_valid = 1'b1;
    in_data = 4'd7;
    #1;
    check("clear_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    clear = 1'b0;
    in_valid = 1'b0;
    check("clear_idle", 32'({busy, out_valid}), 32'd0);
    set_cur(1, 0, 0, 0, 1, 0, 0, 0, 1);
    send_cur(9, 0);
    wait_result(cyc);
    check("post_clear_const", 32'(det_out), 32'h0001);
    take_result("post_clear", 0);

    // Reset pulse during compute step 6
    set_cur(2, 3, 1, 4, 1, 5, 6, 2, 3);
    send_cur(9, 0);
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_det_out", 32'(det_out), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    set_cur(1, 2, 3, 4, 5, 6, 7, 8, 9);
    send_cur(9, 0);
    wait_result(cyc);
    check("singular_const", 32'(det_out), 32'h0000);
    take_result("singular", 0);

    // Random matrices against the model
    for (int n = 0; n < 30; n++) begin
      for (int k = 0; k < 9; k++) cur[k] = $urandom_range(0, 15);
      send_cur(9, $urandom_range(0, 60));
      wait_result(cyc);
      check("rand_latency", 32'(cyc), 32'd12);
      take_result("rand_det", $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
